am_tone_sequencer: RTL and testbench

AM_TONE_SEQUENCER -- requirements
Module: am_tone_sequencer

---
 rtl/am_tone_sequencer.sv | 124 ++++++++++++
 tb/tb_am_tone_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/am_tone_sequencer.sv
// AM tone step sequencer: plays a table of {NCO increment, AM depth, duration}
// entries in order, optionally looping, with registered outputs to the modulator.
module am_tone_sequencer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DUR_W = 24
) (
  input  logic                     CLK,
  input  logic                     RSTb,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [39:0]              wr_inc,
  input  logic [15:0]              wr_scale,
  input  logic [DUR_W-1:0]         wr_dur,
  input  logic [$clog2(DEPTH)-1:0] last_step,
  input  logic                     loop,
  input  logic                     start,
  input  logic                     stop,
  output logic [39:0]              phase_inc_mod,
  output logic [15:0]              mod_scale,
  output logic                     carrier_en,
  output logic                     step_strobe,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [39:0]      tbl_inc   [DEPTH];
  logic [15:0]      tbl_scale [DEPTH];
  logic [DUR_W-1:0] tbl_dur   [DEPTH];

  logic [1:0]       state;
  logic [AW-1:0]    idx;
  logic [DUR_W-1:0] cnt;
  logic [DUR_W-1:0] ld_dur;
  logic [DUR_W-1:0] ld_cnt;

  // Table has no reset so its contents survive RSTb; a same-cycle write to the
  // entry being loaded is seen only on the next visit (old value read here).
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      tbl_inc[wr_addr]   <= wr_inc;
      tbl_scale[wr_addr] <= wr_scale;
      tbl_dur[wr_addr]   <= wr_dur;
    end
  end

  always_comb begin
    ld_dur = tbl_dur[idx];
    ld_cnt = (ld_dur == '0) ? '0 : ld_dur - DUR_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      state         <= ST_IDLE;
      idx           <= '0;
      cnt           <= '0;
      phase_inc_mod <= '0;
      mod_scale     <= '0;
      carrier_en    <= 1'b0;
      step_strobe   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      step_strobe <= 1'b0;
      done        <= 1'b0;
      if (stop) begin
        state         <= ST_IDLE;
        idx           <= '0;
        cnt           <= '0;
        phase_inc_mod <= '0;
        mod_scale     <= '0;
        carrier_en    <= 1'b0;
        busy          <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state <= ST_LOAD;
              idx   <= '0;
              busy  <= 1'b1;
            end
          end
          ST_LOAD: begin
            phase_inc_mod <= tbl_inc[idx];
            mod_scale     <= tbl_scale[idx];
            carrier_en    <= 1'b1;
            step_strobe   <= 1'b1;
            cnt           <= ld_cnt;
            state         <= ST_RUN;
          end
          ST_RUN: begin
            if (cnt != '0) begin
              cnt <= cnt - DUR_W'(1);
            end else if (idx < last_step) begin
              idx   <= idx + AW'(1);
              state <= ST_LOAD;
            end else if (loop) begin
              idx   <= '0;
              state <= ST_LOAD;
            end else begin
              state         <= ST_DONE;
              done          <= 1'b1;
              phase_inc_mod <= '0;
              mod_scale     <= '0;
              carrier_en    <= 1'b0;
            end
          end
          default: begin
            state <= ST_IDLE;
            idx   <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_am_tone_sequencer.sv
// Directed bench for am_tone_sequencer: timing, looping, stop, reset, table hazards.
module tb_am_tone_sequencer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned DUR_W = 24;

  logic             CLK = 1'b0;
  logic             RSTb;
  logic             wr_en;
  logic [2:0]       wr_addr;
  logic [39:0]      wr_inc;
  logic [15:0]      wr_scale;
  logic [DUR_W-1:0] wr_dur;
  logic [2:0]       last_step;
  logic             loop;
  logic             start;
  logic             stop;
  logic [39:0]      phase_inc_mod;
  logic [15:0]      mod_scale;
  logic             carrier_en;
  logic             step_strobe;
  logic             busy;
  logic             done;

  int errs   = 0;
  int checks = 0;

  int          st_t   [16];
  logic [39:0] st_inc [16];
  int          st_n;
  bit          done_seen;
  int          waited;

  am_tone_sequencer #(.DEPTH(DEPTH), .DUR_W(DUR_W)) dut (
    .CLK(CLK), .RSTb(RSTb), .wr_en(wr_en), .wr_addr(wr_addr), .wr_inc(wr_inc),
    .wr_scale(wr_scale), .wr_dur(wr_dur), .last_step(last_step), .loop(loop),
    .start(start), .stop(stop), .phase_inc_mod(phase_inc_mod), .mod_scale(mod_scale),
    .carrier_en(carrier_en), .step_strobe(step_strobe), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [39:0] inc, input logic [15:0] sc,
                    input logic [DUR_W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_inc = inc; wr_scale = sc; wr_dur = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic stop_pulse();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  // start must already be high; t counts cycles after the start cycle
  task automatic observe(input int n);
    st_n = 0;
    done_seen = 0;
    for (int t = 1; t <= n; t++) begin
      tick();
      if (t == 1) start = 1'b0;
      if (step_strobe && st_n < 16) begin
        st_t[st_n]   = t;
        st_inc[st_n] = phase_inc_mod;
        st_n++;
      end
      if (done) done_seen = 1;
    end
  endtask

  initial begin
    logic [39:0] exp_inc2 [5];
    int          exp_gap2 [4];
    exp_inc2 = '{40'h111, 40'h222, 40'h111, 40'h222, 40'h111};
    exp_gap2 = '{4, 3, 4, 3};

    RSTb = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_inc = '0; wr_scale = '0; wr_dur = '0;
    last_step = '0; loop = 1'b0; start = 1'b0; stop = 1'b0;
    tick(); tick();
    check("rst_inc", phase_inc_mod, 0);
    check("rst_scale", mod_scale, 0);
    check("rst_flags", {carrier_en, step_strobe, busy, done}, 0);
    RSTb = 1'b1;
    tick();

    // single non-looping step, dur 4
    wr(0, 40'hA7C5AC, 16'h0CCC, 4);
    last_step = 0; loop = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_load_busy", busy, 1);
    check("t1_load_strobe", step_strobe, 0);
    check("t1_load_carrier", carrier_en, 0);
    tick();
    check("t1_strobe", step_strobe, 1);
    check("t1_inc", phase_inc_mod, 40'hA7C5AC);
    check("t1_scale", mod_scale, 16'h0CCC);
    check("t1_carrier", carrier_en, 1);
    for (int c = 3; c <= 5; c++) begin
      tick();
      check("t1_hold_inc", phase_inc_mod, 40'hA7C5AC);
      check("t1_hold_strobe", {step_strobe, done}, 0);
    end
    tick();
    check("t1_done", done, 1);
    check("t1_done_out", {phase_inc_mod, mod_scale, carrier_en}, 0);
    check("t1_done_busy", busy, 1);
    tick();
    check("t1_idle", {busy, done}, 0);

    // two-entry loop, dur 3/2: strobe gaps 4,3,4,3
    wr(0, 40'h111, 16'h1000, 3);
    wr(1, 40'h222, 16'h2000, 2);
    last_step = 1; loop = 1'b1;
    start = 1'b1;
    observe(17);
    check("t2_nstrobe", st_n, 5);
    check("t2_first", st_t[0], 2);
    for (int k = 0; k < 5; k++) begin
      check("t2_inc", st_inc[k], exp_inc2[k]);
      if (k > 0) check("t2_gap", st_t[k] - st_t[k-1], exp_gap2[k-1]);
    end
    check("t2_no_done", done_seen, 0);
    check("t2_scale", mod_scale, 16'h1000);
    // loop sampled at the decision: drop it mid-sequence, done follows entry 1
    loop = 1'b0;
    waited = 0;
    while (!done && waited < 20) begin
      tick();
      waited++;
    end
    check("t2_done_wait", waited, 5);
    tick();
    check("t2_idle", busy, 0);

    // dur 0 behaves as dur 1: every step is 2 cycles
    wr(0, 40'h333, 16'h0333, 0);
    wr(1, 40'h444, 16'h0444, 1);
    loop = 1'b1;
    start = 1'b1;
    observe(9);
    check("t3_nstrobe", st_n, 4);
    for (int k = 1; k < 4; k++) check("t3_gap", st_t[k] - st_t[k-1], 2);
    check("t3_inc0", st_inc[0], 40'h333);
    check("t3_inc1", st_inc[1], 40'h444);
    stop_pulse();
    check("t3_stopped", busy, 0);

    // stop inside a 10-cycle step
    wr(0, 40'h555, 16'h0555, 2);
    wr(1, 40'h666, 16'h0666, 10);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 2; c <= 5; c++) tick();
    check("t4_step1", {step_strobe, phase_inc_mod}, {1'b1, 40'h666});
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t4_stop_flags", {busy, carrier_en, done, step_strobe}, 0);
    check("t4_stop_out", {phase_inc_mod, mod_scale}, 0);
    tick(); tick();
    check("t4_no_done", {busy, done}, 0);
    start = 1'b1;
    observe(2);
    check("t4_restart", {st_n[3:0], st_inc[0]}, {4'd1, 40'h555});

    // reset mid-RUN keeps the table
    tick();
    check("t5_running", carrier_en, 1);
    RSTb = 1'b0;
    tick();
    check("t5_rst_out", {phase_inc_mod, mod_scale}, 0);
    check("t5_rst_flags", {carrier_en, step_strobe, busy, done}, 0);
    RSTb = 1'b1;
    start = 1'b1;
    observe(6);
    check("t5_nstrobe", st_n, 2);
    check("t5_t", {st_t[0][7:0], st_t[1][7:0]}, {8'd2, 8'd5});
    check("t5_inc", {st_inc[0], st_inc[1]}, {40'h555, 40'h666});
    stop_pulse();

    // write to the entry during its own LOAD cycle
    wr(0, 40'h777, 16'h0777, 2);
    wr(1, 40'h888, 16'h0888, 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    wr_en = 1'b1; wr_addr = 0; wr_inc = 40'h1; wr_scale = 16'h0001; wr_dur = 2;
    tick();
    wr_en = 1'b0;
    check("t6_old", {step_strobe, phase_inc_mod}, {1'b1, 40'h777});
    tick(); tick(); tick();
    check("t6_e1", {step_strobe, phase_inc_mod}, {1'b1, 40'h888});
    tick(); tick(); tick();
    check("t6_new", {step_strobe, phase_inc_mod}, {1'b1, 40'h1});
    check("t6_new_scale", mod_scale, 16'h0001);
    stop_pulse();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
